// File: rtl/proc_core.sv
`default_nettype none
// ============================================================================
//  Module   : proc_core
//  Brief    : Multi-cycle accumulator-free core: IDLE/READ/EXEC/WB sequencer
//             over a small register file with NZC flags and a HALT state.
//  Revision : 1.0 - initial release
// ============================================================================
module proc_core #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS),
    localparam int IW = 4 + 3*AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             instr_valid,
    input  logic [IW-1:0]    instr_data,
    output logic             instr_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [AW-1:0]    res_addr,
    output logic [2:0]       flags,
    output logic             halted,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_read = 3'd1;
    localparam logic [2:0] c_st_exec = 3'd2;
    localparam logic [2:0] c_st_wb   = 3'd3;
    localparam logic [2:0] c_st_halt = 3'd4;

    localparam logic [3:0] c_op_add  = 4'd1;
    localparam logic [3:0] c_op_sub  = 4'd2;
    localparam logic [3:0] c_op_and  = 4'd3;
    localparam logic [3:0] c_op_or   = 4'd4;
    localparam logic [3:0] c_op_xor  = 4'd5;
    localparam logic [3:0] c_op_not  = 4'd6;
    localparam logic [3:0] c_op_shl  = 4'd7;
    localparam logic [3:0] c_op_shr  = 4'd8;
    localparam logic [3:0] c_op_mov  = 4'd9;
    localparam logic [3:0] c_op_ldi  = 4'd10;
    localparam logic [3:0] c_op_halt = 4'd15;

    localparam int c_imw = 2*AW;
    localparam int c_iml = (c_imw < WIDTH) ? c_imw : WIDTH;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [IW-1:0]    r_instr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [2:0]       r_flags;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [AW-1:0]    r_res_addr;

    logic [3:0]       w_op;
    logic [AW-1:0]    w_rd;
    logic [AW-1:0]    w_rs1;
    logic [AW-1:0]    w_rs2;
    logic             w_writes;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;

    assign w_op     = r_instr[IW-1 -: 4];
    assign w_rd     = r_instr[3*AW-1 -: AW];
    assign w_rs1    = r_instr[2*AW-1 -: AW];
    assign w_rs2    = r_instr[AW-1:0];
    assign w_writes = (w_op >= c_op_add) && (w_op <= c_op_ldi);

    // Immediate is {rs1,rs2}: zero-extended or truncated to WIDTH
    always_comb begin
        w_imm = '0;
        for (int i = 0; i < c_iml; i++) begin
            w_imm[i] = r_instr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else if (enable) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        case (r_state)
            c_st_idle: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next = c_st_read;
            end
            c_st_read: w_next = c_st_exec;
            c_st_exec: w_next = (w_op == c_op_halt) ? c_st_halt : c_st_wb;
            c_st_wb:   w_next = c_st_idle;
            c_st_halt: w_next = c_st_halt;
            default:   w_next = c_st_idle;
        endcase
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // w_c defaults to the held carry so MOV/LDI leave C untouched
    always_comb begin
        w_res = '0;
        w_c   = r_flags[0];
        case (w_op)
            c_op_add: begin w_res = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH];  end
            c_op_sub: begin w_res = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; end
            c_op_and: begin w_res = r_a & r_b; w_c = 1'b0; end
            c_op_or:  begin w_res = r_a | r_b; w_c = 1'b0; end
            c_op_xor: begin w_res = r_a ^ r_b; w_c = 1'b0; end
            c_op_not: begin w_res = ~r_a;      w_c = 1'b0; end
            c_op_shl: begin w_res = {r_a[WIDTH-2:0], 1'b0}; w_c = r_a[WIDTH-1]; end
            c_op_shr: begin w_res = {1'b0, r_a[WIDTH-1:1]}; w_c = r_a[0];       end
            c_op_mov: w_res = r_a;
            c_op_ldi: w_res = w_imm;
            default:  w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_addr  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (enable) begin
            r_res_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (instr_valid) r_instr <= instr_data;
                end
                c_st_read: begin
                    r_a <= r_regs[w_rs1];
                    r_b <= r_regs[w_rs2];
                end
                c_st_exec: begin
                    if (w_writes) begin
                        r_result <= w_res;
                        r_flags  <= {w_res[WIDTH-1], (w_res == '0), w_c};
                    end
                end
                c_st_wb: begin
                    if (w_writes) begin
                        r_regs[w_rd] <= r_result;
                        r_res_valid  <= 1'b1;
                        r_res_data   <= r_result;
                        r_res_addr   <= w_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_addr  = r_res_addr;
    assign flags     = r_flags;
    assign halted    = (r_state == c_st_halt);
    assign dbg_data  = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_proc_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_core
//  Brief    : Directed self-checking bench for proc_core (8x8 and 16x16 builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;

    logic        iv_a;
    logic [12:0] id_a;
    logic        ir_a, rv_a, hl_a;
    logic [7:0]  rd_a, dd_a;
    logic [2:0]  ra_a, fl_a, da_a;

    logic        iv_b;
    logic [15:0] id_b;
    logic        ir_b, rv_b, hl_b;
    logic [15:0] rdat_b, dd_b;
    logic [3:0]  radr_b, da_b;
    logic [2:0]  fl_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    proc_core #(.WIDTH(8), .NREGS(8)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable),
        .instr_valid(iv_a), .instr_data(id_a), .instr_ready(ir_a),
        .res_valid(rv_a), .res_data(rd_a), .res_addr(ra_a),
        .flags(fl_a), .halted(hl_a), .dbg_addr(da_a), .dbg_data(dd_a)
    );

    proc_core #(.WIDTH(16), .NREGS(16)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable),
        .instr_valid(iv_b), .instr_data(id_b), .instr_ready(ir_b),
        .res_valid(rv_b), .res_data(rdat_b), .res_addr(radr_b),
        .flags(fl_b), .halted(hl_b), .dbg_addr(da_b), .dbg_data(dd_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] ea(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] r1, input logic [2:0] r2);
        return {op, rd, r1, r2};
    endfunction

    function automatic logic [12:0] la(input logic [2:0] rd, input logic [5:0] imm);
        return {4'd10, rd, imm};
    endfunction

    function automatic logic [15:0] eb(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] r1, input logic [3:0] r2);
        return {op, rd, r1, r2};
    endfunction

    function automatic logic [15:0] lb(input logic [3:0] rd, input logic [7:0] imm);
        return {4'd10, rd, imm};
    endfunction

    // One instruction from IDLE through writeback; s selects the 16-bit build
    task automatic run(input logic s, input string tag, input logic [15:0] instr,
                       input logic wr, input logic [3:0] addr, input logic [15:0] data,
                       input logic [2:0] fl);
        check({tag, "/ready"}, s ? ir_b : ir_a, 1);
        if (s) begin iv_b = 1'b1; id_b = instr; end
        else   begin iv_a = 1'b1; id_a = instr[12:0]; end
        step();
        iv_a = 1'b0;
        iv_b = 1'b0;
        check({tag, "/busy"}, s ? ir_b : ir_a, 0);
        step();
        step();
        check({tag, "/early"}, s ? rv_b : rv_a, 0);
        step();
        check({tag, "/res_valid"}, s ? rv_b : rv_a, wr);
        if (wr) begin
            check({tag, "/res_addr"}, s ? radr_b : {1'b0, ra_a}, addr);
            check({tag, "/res_data"}, s ? rdat_b : {8'h00, rd_a}, data);
        end
        check({tag, "/flags"}, s ? fl_b : fl_a, fl);
    endtask

    task automatic dbg(input logic s, input string tag, input logic [3:0] addr,
                       input logic [15:0] exp);
        if (s) da_b = addr;
        else   da_a = addr[2:0];
        #1;
        check(tag, s ? dd_b : {8'h00, dd_a}, exp);
    endtask

    initial begin
        int n_rdy, n_rv, n_bad;
        rst = 1'b1; enable = 1'b1;
        iv_a = 1'b0; id_a = '0; da_a = '0;
        iv_b = 1'b0; id_b = '0; da_b = '0;
        step();
        step();
        rst = 1'b0;
        check("reset/ready", ir_a, 1);
        check("reset/res_valid", rv_a, 0);
        check("reset/res_data", rd_a, 0);
        check("reset/res_addr", ra_a, 0);
        check("reset/flags", fl_a, 0);
        check("reset/halted", hl_a, 0);

        run(0, "ldi_r1", la(1, 6'h05), 1, 1, 16'h05, 3'b000);
        run(0, "ldi_r2", la(2, 6'h03), 1, 2, 16'h03, 3'b000);
        run(0, "add_r3", ea(1, 3, 1, 2), 1, 3, 16'h08, 3'b000);
        dbg(0, "dbg_r3", 3, 16'h08);

        run(0, "ldi_r1_0", la(1, 6'h00), 1, 1, 16'h00, 3'b010);
        run(0, "not_r1", ea(6, 1, 1, 0), 1, 1, 16'hFF, 3'b100);
        run(0, "ldi_r2_1", la(2, 6'h01), 1, 2, 16'h01, 3'b000);
        run(0, "add_wrap", ea(1, 4, 1, 2), 1, 4, 16'h00, 3'b011);
        run(0, "sub_borrow", ea(2, 5, 2, 1), 1, 5, 16'h02, 3'b001);
        run(0, "xor", ea(5, 6, 1, 2), 1, 6, 16'hFE, 3'b100);
        run(0, "shl", ea(7, 7, 1, 0), 1, 7, 16'hFE, 3'b101);
        run(0, "shr", ea(8, 7, 2, 0), 1, 7, 16'h00, 3'b011);
        run(0, "mov", ea(9, 6, 5, 0), 1, 6, 16'h02, 3'b001);
        run(0, "nop", ea(0, 3, 1, 2), 0, 0, 16'h00, 3'b001);
        run(0, "reserved", ea(13, 3, 1, 2), 0, 0, 16'h00, 3'b001);
        dbg(0, "dbg_r3_kept", 3, 16'h08);
        run(0, "and", ea(3, 6, 1, 2), 1, 6, 16'h01, 3'b000);
        run(0, "or", ea(4, 3, 3, 2), 1, 3, 16'h09, 3'b000);
        dbg(0, "dbg_r5", 5, 16'h02);

        // instr_valid held: r6 += r2 must happen exactly three times
        n_rdy = 0; n_rv = 0; n_bad = 0;
        iv_a = 1'b1;
        id_a = ea(1, 6, 6, 2);
        for (int k = 0; k < 12; k++) begin
            if (ir_a) n_rdy++;
            if (ir_a !== ((k % 4) == 0)) n_bad++;
            step();
            if (rv_a) n_rv++;
        end
        iv_a = 1'b0;
        check("stream/accepts", n_rdy, 3);
        check("stream/ready_pattern", n_bad, 0);
        check("stream/res_pulses", n_rv, 3);
        dbg(0, "stream/r6", 6, 16'h04);

        // enable dropped for three cycles while ADD sits in EXEC
        iv_a = 1'b1;
        id_a = ea(1, 7, 5, 2);
        step();
        iv_a = 1'b0;
        step();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("freeze/ready", ir_a, 0);
            check("freeze/res_valid", rv_a, 0);
        end
        enable = 1'b1;
        step();
        check("freeze/early", rv_a, 0);
        step();
        check("freeze/res_valid", rv_a, 1);
        check("freeze/res_data", rd_a, 8'h03);
        check("freeze/res_addr", ra_a, 7);
        step();
        check("freeze/one_pulse", rv_a, 0);
        dbg(0, "freeze/r7", 7, 16'h03);

        // reset lands on the WB edge of LDI r1,0x0A
        iv_a = 1'b1;
        id_a = la(1, 6'h0A);
        step();
        iv_a = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wb/res_valid", rv_a, 0);
        check("rst_wb/ready", ir_a, 1);
        check("rst_wb/flags", fl_a, 0);
        dbg(0, "rst_wb/r1", 1, 16'h00);
        step();
        check("rst_wb/no_late_wb", rv_a, 0);
        dbg(0, "rst_wb/r1_after", 1, 16'h00);

        run(0, "ldi_r1_0a", la(1, 6'h0A), 1, 1, 16'h0A, 3'b000);
        iv_a = 1'b1;
        id_a = ea(15, 0, 0, 0);
        step();
        iv_a = 1'b0;
        step();
        step();
        check("halt/halted", hl_a, 1);
        check("halt/ready", ir_a, 0);
        n_bad = 0;
        iv_a = 1'b1;
        id_a = la(1, 6'h3F);
        for (int k = 0; k < 6; k++) begin
            step();
            if (ir_a || rv_a || !hl_a) n_bad++;
        end
        iv_a = 1'b0;
        check("halt/held", n_bad, 0);
        dbg(0, "halt/r1", 1, 16'h0A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst/halted", hl_a, 0);
        check("halt_rst/ready", ir_a, 1);
        n_bad = 0;
        for (int k = 0; k < 8; k++) begin
            da_a = 3'(k);
            #1;
            if (dd_a !== 8'h00) n_bad++;
        end
        check("halt_rst/regs_zero", n_bad, 0);

        step();
        run(1, "w16/ldi_r1", lb(1, 8'h00), 1, 1, 16'h0000, 3'b010);
        run(1, "w16/not_r1", eb(6, 1, 1, 0), 1, 1, 16'hFFFF, 3'b100);
        run(1, "w16/ldi_r2", lb(2, 8'h01), 1, 2, 16'h0001, 3'b000);
        run(1, "w16/add_wrap", eb(1, 3, 1, 2), 1, 3, 16'h0000, 3'b011);
        run(1, "w16/ldi_ext", lb(4, 8'hAB), 1, 4, 16'h00AB, 3'b001);
        dbg(1, "w16/dbg_r1", 1, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
